// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types and constants for the SDRAM write-merge buffer
package sdram_pkg;

  typedef enum logic [0:0] {
    WAITWRITE = 1'b0,
    FILL      = 1'b1
  } wb_state_e;

  localparam int         BURST_WORDS = 4;
  localparam logic [7:0] DQM_IDLE    = 8'hFF;
  localparam int         LINE_LSB    = 3;

  // Byte-lane merge: an active-low strobe selects the new byte, otherwise the old one survives.
  function automatic logic [15:0] merge_word(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic        rwl_n,
                                             input logic        rwu_n);
    logic [15:0] res;
    res[15:8] = rwu_n ? old_w[15:8] : new_w[15:8];
    res[7:0]  = rwl_n ? old_w[7:0]  : new_w[7:0];
    return res;
  endfunction

endpackage

// File: rtl/sdram_write_buffer.sv
// rtl/sdram_write_buffer.sv - single-line write-merge buffer feeding masked SDRAM bursts
module sdram_write_buffer
  import sdram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic        cpu_rwl,
  input  logic        cpu_rwu,
  input  logic [15:0] data_from_cpu,
  output logic        cpu_ack,
  input  logic [31:0] probe_addr,
  output logic        probe_hit,
  output logic        sdram_req,
  output logic [31:0] sdram_addr,
  input  logic        sdram_burst,
  output logic [15:0] data_to_sdram,
  output logic [1:0]  sdram_dqm
);

  wb_state_e                         state_q;
  logic [31-LINE_LSB:0]              line_addr_q;
  logic [BURST_WORDS-1:0][15:0]      word_q;
  logic [7:0]                        dqm_q;
  logic [7:0]                        dqm_d;
  logic [15:0]                       word_d;
  logic                              dirty_q;
  logic [1:0]                        wcnt_q;
  logic                              ack_hold_q;
  logic                              cpu_ack_q;
  logic                              sdram_req_q;

  logic [1:0] wsel;
  logic       line_match;
  logic       accept;
  logic       burst_live;
  logic       unused_ok;

  assign wsel       = cpu_addr[2:1];
  assign line_match = (cpu_addr[31:LINE_LSB] == line_addr_q);
  assign burst_live = sdram_burst && dirty_q;

  // Any burst cycle blocks acceptance so the line never changes under a flush.
  assign accept = (state_q == WAITWRITE) && cpu_req && !cpu_rw && !ack_hold_q &&
                  !sdram_burst && (!dirty_q || line_match);

  always_comb begin
    dqm_d                    = dqm_q;
    dqm_d[{wsel, 1'b0} +: 2] = dqm_q[{wsel, 1'b0} +: 2] & {cpu_rwu, cpu_rwl};
    word_d                   = merge_word(word_q[wsel], data_from_cpu, cpu_rwl, cpu_rwu);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAITWRITE;
      line_addr_q <= '0;
      word_q      <= '0;
      dqm_q       <= DQM_IDLE;
      dirty_q     <= 1'b0;
      wcnt_q      <= 2'd0;
      ack_hold_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      sdram_req_q <= 1'b0;
    end else begin
      cpu_ack_q <= accept;

      if (!cpu_req) begin
        ack_hold_q <= 1'b0;
      end else if (accept) begin
        ack_hold_q <= 1'b1;
      end

      if (burst_live) begin
        wcnt_q <= wcnt_q + 2'd1;
      end

      case (state_q)
        WAITWRITE: begin
          if (accept) begin
            line_addr_q  <= cpu_addr[31:LINE_LSB];
            word_q[wsel] <= word_d;
            dqm_q        <= dqm_d;
            dirty_q      <= 1'b1;
            sdram_req_q  <= 1'b1;
          end else if (burst_live) begin
            state_q     <= FILL;
            sdram_req_q <= 1'b0;
          end
        end
        FILL: begin
          // Word data is left in place; the all-ones mask hides it from the next flush.
          if (!sdram_burst) begin
            dirty_q <= 1'b0;
            dqm_q   <= DQM_IDLE;
            wcnt_q  <= 2'd0;
            state_q <= WAITWRITE;
          end
        end
        default: state_q <= WAITWRITE;
      endcase
    end
  end

  assign cpu_ack       = cpu_ack_q;
  assign sdram_req     = sdram_req_q;
  assign sdram_addr    = {line_addr_q, {LINE_LSB{1'b0}}};
  assign probe_hit     = dirty_q && (probe_addr[31:LINE_LSB] == line_addr_q);
  assign data_to_sdram = word_q[wcnt_q];
  assign sdram_dqm     = dqm_q[{wcnt_q, 1'b0} +: 2];

  assign unused_ok = ^{cpu_addr[0], probe_addr[LINE_LSB-1:0]};

endmodule
